// File: rtl/series_sum_engine.sv
// Saturating series accumulator: sums i or i*i for i = 0..N per job.
// Jobs are loaded through a start handshake and can be cancelled with abort.
module series_sum_engine #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  n_limit,
   input  logic              mode,
   input  logic              abort,
   output logic [DATA_W-1:0] sum,
   output logic [CNT_W-1:0]  count,
   output logic              busy,
   output logic              done,
   output logic              overflow
);

   localparam int PROD_W = 2 * CNT_W;
   localparam int ACC_W  = ((DATA_W > PROD_W) ? DATA_W : PROD_W) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [ACC_W-1:0] SUM_MAX = ACC_W'({DATA_W{1'b1}});

   logic [1:0]        state, state_n;
   logic [CNT_W-1:0]  n_reg, n_n;
   logic              mode_reg, mode_n;
   logic [DATA_W-1:0] sum_n;
   logic [CNT_W-1:0]  count_n;
   logic              ovf_n;

   logic [PROD_W-1:0] idx_w;
   logic [PROD_W-1:0] term;
   logic [ACC_W-1:0]  acc;
   logic              sat;
   logic [DATA_W-1:0] sum_sat;
   logic              last;

   assign idx_w = PROD_W'(count);
   assign term  = mode_reg ? (idx_w * idx_w) : idx_w;
   assign acc   = ACC_W'(sum) + ACC_W'(term);
   assign sat   = (acc > SUM_MAX);
   // Once the sum pins at all-ones it stays there: terms are never negative.
   assign sum_sat = sat ? {DATA_W{1'b1}} : acc[DATA_W-1:0];
   assign last    = (count == n_reg);

   always_comb begin
      state_n = state;
      sum_n   = sum;
      count_n = count;
      ovf_n   = overflow;
      n_n     = n_reg;
      mode_n  = mode_reg;
      unique case (state)
         S_IDLE: begin
            if (start && !abort) begin
               state_n = S_RUN;
               sum_n   = '0;
               count_n = '0;
               ovf_n   = 1'b0;
               n_n     = n_limit;
               mode_n  = mode;
            end
         end
         S_RUN: begin
            if (abort) begin
               state_n = S_IDLE;
            end else begin
               sum_n = sum_sat;
               ovf_n = overflow | sat;
               if (last) begin
                  state_n = S_DONE;
               end else begin
                  count_n = count + CNT_W'(1);
               end
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         sum      <= '0;
         count    <= '0;
         overflow <= 1'b0;
         n_reg    <= '0;
         mode_reg <= 1'b0;
      end else begin
         state    <= state_n;
         sum      <= sum_n;
         count    <= count_n;
         overflow <= ovf_n;
         n_reg    <= n_n;
         mode_reg <= mode_n;
      end
   end

   assign busy = (state == S_RUN);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_series_sum_engine.sv
// Directed bench for series_sum_engine: job sums, saturation, abort,
// ignored start and asynchronous reset.
module tb_series_sum_engine;

   logic       clk;
   logic       rst;
   logic       start;
   logic [4:0] n_limit;
   logic       mode;
   logic       abort;
   logic [7:0] sum;
   logic [4:0] count;
   logic       busy;
   logic       done;
   logic       overflow;

   int ncmp;
   int nerr;
   int bc;
   int dc;
   int dat;
   int k;

   series_sum_engine #(.DATA_W(8), .CNT_W(5)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .n_limit  (n_limit),
      .mode     (mode),
      .abort    (abort),
      .sum      (sum),
      .count    (count),
      .busy     (busy),
      .done     (done),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      ncmp++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input int n, input int m);
      start   = 1'b1;
      n_limit = 5'(n);
      mode    = m[0];
      tick();
      start   = 1'b0;
   endtask

   // Counts busy/done samples until the engine is idle again.
   task automatic finish_job(output int b, output int d, output int at);
      int i;
      b  = 0;
      d  = 0;
      at = -1;
      for (i = 0; i < 200; i++) begin
         if (busy) b++;
         if (done) begin
            d++;
            if (at < 0) at = i;
         end
         if (!busy && !done) break;
         tick();
      end
      chk("job_bound", int'(i < 200), 1);
   endtask

   task automatic wait_count(input int c);
      int i;
      for (i = 0; i < 100; i++) begin
         if (count == 5'(c)) break;
         tick();
      end
      chk("wait_bound", int'(i < 100), 1);
   endtask

   initial begin
      ncmp    = 0;
      nerr    = 0;
      rst     = 1'b0;
      start   = 1'b0;
      n_limit = '0;
      mode    = 1'b0;
      abort   = 1'b0;
      tick();
      tick();
      chk("rst_sum", int'(sum), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_ovf", int'(overflow), 0);
      rst = 1'b1;
      tick();

      start_job(16, 0);
      chk("j16_busy0", int'(busy), 1);
      finish_job(bc, dc, dat);
      chk("j16_busycyc", bc, 17);
      chk("j16_dones", dc, 1);
      chk("j16_doneat", dat, 17);
      chk("j16_sum", int'(sum), 136);
      chk("j16_ovf", int'(overflow), 0);
      tick();
      tick();
      chk("j16_hold_sum", int'(sum), 136);
      chk("j16_hold_cnt", int'(count), 16);

      start_job(5, 1);
      finish_job(bc, dc, dat);
      chk("sq5_busycyc", bc, 6);
      chk("sq5_sum", int'(sum), 55);
      chk("sq5_ovf", int'(overflow), 0);

      start_job(22, 0);
      finish_job(bc, dc, dat);
      chk("j22_sum", int'(sum), 253);
      chk("j22_ovf", int'(overflow), 0);

      start_job(23, 0);
      finish_job(bc, dc, dat);
      chk("j23_sum", int'(sum), 255);
      chk("j23_ovf", int'(overflow), 1);
      chk("j23_doneat", dat, 24);
      chk("j23_dones", dc, 1);

      start_job(0, 0);
      finish_job(bc, dc, dat);
      chk("j0_busycyc", bc, 1);
      chk("j0_doneat", dat, 1);
      chk("j0_sum", int'(sum), 0);
      chk("j0_ovf", int'(overflow), 0);

      start_job(31, 0);
      finish_job(bc, dc, dat);
      chk("j31_sum", int'(sum), 255);
      chk("j31_ovf", int'(overflow), 1);

      start   = 1'b1;
      abort   = 1'b1;
      n_limit = 5'd3;
      tick();
      start   = 1'b0;
      abort   = 1'b0;
      chk("sa_idle_busy", int'(busy), 0);
      chk("sa_idle_sum", int'(sum), 255);

      start_job(16, 0);
      wait_count(5);
      start   = 1'b1;
      n_limit = 5'd3;
      tick();
      start   = 1'b0;
      finish_job(bc, dc, dat);
      chk("ign_sum", int'(sum), 136);
      chk("ign_dones", dc, 1);
      chk("ign_count", int'(count), 16);

      start_job(16, 0);
      wait_count(5);
      chk("ab_pre_sum", int'(sum), 10);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("ab_busy", int'(busy), 0);
      chk("ab_done", int'(done), 0);
      chk("ab_sum", int'(sum), 10);
      chk("ab_count", int'(count), 5);
      dc = 0;
      for (k = 0; k < 4; k++) begin
         if (done) dc++;
         tick();
      end
      chk("ab_nodone", dc, 0);
      chk("ab_hold_sum", int'(sum), 10);

      start_job(31, 1);
      wait_count(10);
      chk("ar_pre_sum", int'(sum), 255);
      chk("ar_pre_ovf", int'(overflow), 1);
      #2;
      rst = 1'b0;
      #1;
      chk("ar_sum", int'(sum), 0);
      chk("ar_count", int'(count), 0);
      chk("ar_ovf", int'(overflow), 0);
      chk("ar_busy", int'(busy), 0);
      chk("ar_done", int'(done), 0);
      #2;
      rst = 1'b1;
      tick();
      start_job(4, 0);
      finish_job(bc, dc, dat);
      chk("post_sum", int'(sum), 10);
      chk("post_busycyc", bc, 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
